// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch
// Purpose  : RV32I fetch stage. Owns the PC, runs the imem req/rvalid handshake
//            (one request outstanding at most), and holds the 1-entry skid
//            buffer and the IF/ID register. Define IF_PERF_CNT_EN to add
//            o_fetch_count.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(32'h0000_0000),
  parameter logic [DATA_WIDTH-1:0] NOP_INST   = DATA_WIDTH'(32'h0000_0013)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clk_en,
  input  logic                  i_stall,
  input  logic                  i_flush,
  input  logic [DATA_WIDTH-1:0] i_redirect_pc,
  output logic                  o_imem_req,
  output logic [DATA_WIDTH-1:0] o_imem_addr,
  input  logic                  i_imem_ready,
  input  logic                  i_imem_rvalid,
  input  logic [DATA_WIDTH-1:0] i_imem_rdata,
  output logic [DATA_WIDTH-1:0] o_if_inst,
  output logic [DATA_WIDTH-1:0] o_if_pc,
  output logic                  o_if_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]           o_fetch_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_req_pc;
  logic [DATA_WIDTH-1:0] r_skid_inst;
  logic [DATA_WIDTH-1:0] r_skid_pc;
  logic                  r_skid_valid;
  logic                  r_kill;

  logic                  w_accept;
  logic                  w_deliver;
  logic                  w_kill_next;
  logic [DATA_WIDTH-1:0] w_redirect;

  // A full skid buffer throttles fetch so at most one word is ever pending.
  assign o_imem_req  = (r_state == S_REQ) && !r_skid_valid;
  assign o_imem_addr = r_pc;

  assign w_accept    = o_imem_req && i_imem_ready;
  assign w_deliver   = (r_state == S_WAIT) && i_imem_rvalid && !r_kill && !i_flush;
  assign w_redirect  = i_redirect_pc & ~DATA_WIDTH'(3);

  // On flush, anything accepted now or still in flight must be discarded later.
  assign w_kill_next = w_accept || ((r_state == S_WAIT) && !i_imem_rvalid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_req_pc     <= RESET_PC;
      r_skid_inst  <= NOP_INST;
      r_skid_pc    <= '0;
      r_skid_valid <= 1'b0;
      r_kill       <= 1'b0;
      o_if_inst    <= NOP_INST;
      o_if_pc      <= '0;
      o_if_valid   <= 1'b0;
    end else if (clk_en) begin
      if (i_flush) begin
        r_pc         <= w_redirect;
        r_skid_valid <= 1'b0;
        r_kill       <= w_kill_next;
        r_state      <= w_kill_next ? S_WAIT : S_REQ;
        o_if_inst    <= NOP_INST;
        o_if_pc      <= '0;
        o_if_valid   <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: r_state <= S_REQ;
          S_REQ: begin
            if (w_accept) begin
              r_req_pc <= r_pc;
              r_pc     <= r_pc + DATA_WIDTH'(4);
              r_state  <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (i_imem_rvalid) begin
              r_kill  <= 1'b0;
              r_state <= S_REQ;
            end
          end
          default: r_state <= S_IDLE;
        endcase

        if (!i_stall) begin
          if (r_skid_valid) begin
            o_if_inst    <= r_skid_inst;
            o_if_pc      <= r_skid_pc;
            o_if_valid   <= 1'b1;
            r_skid_valid <= 1'b0;
          end else if (w_deliver) begin
            o_if_inst  <= i_imem_rdata;
            o_if_pc    <= r_req_pc;
            o_if_valid <= 1'b1;
          end else begin
            o_if_inst  <= NOP_INST;
            o_if_pc    <= '0;
            o_if_valid <= 1'b0;
          end
        end else if (w_deliver) begin
          r_skid_inst  <= i_imem_rdata;
          r_skid_pc    <= r_req_pc;
          r_skid_valid <= 1'b1;
        end
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  // Counted at the moment a word is accepted into IF/ID or skid, never again
  // when it moves from skid to IF/ID.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_fetch_count <= '0;
    end else if (clk_en && w_deliver && (o_fetch_count != 32'hFFFF_FFFF)) begin
      o_fetch_count <= o_fetch_count + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// Bench for instruction_fetch: directed scenarios, then a randomized run scored
// against a transaction-level model (sequential PC stream restarted by redirects).
module tb_instruction_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clk_en;
  logic        i_stall;
  logic        i_flush;
  logic [31:0] i_redirect_pc;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ready;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic [31:0] o_if_inst;
  logic [31:0] o_if_pc;
  logic        o_if_valid;
`ifdef IF_PERF_CNT_EN
  logic [31:0] o_fetch_count;
`endif

  int total = 0;
  int bad   = 0;

  // memory model: one pending response with a countdown
  bit          pend, pend_killed, poison;
  logic [31:0] pend_addr, poison_data;
  int          pend_lat;
  int          lat_min = 1;
  int          lat_max = 1;

  // architectural expectations
  logic [31:0] exp_pc, exp_req, exp_cnt;
  int          delivered = 0;

  instruction_fetch dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clk_en       (clk_en),
    .i_stall      (i_stall),
    .i_flush      (i_flush),
    .i_redirect_pc(i_redirect_pc),
    .o_imem_req   (o_imem_req),
    .o_imem_addr  (o_imem_addr),
    .i_imem_ready (i_imem_ready),
    .i_imem_rvalid(i_imem_rvalid),
    .i_imem_rdata (i_imem_rdata),
    .o_if_inst    (o_if_inst),
    .o_if_pc      (o_if_pc),
    .o_if_valid   (o_if_valid)
`ifdef IF_PERF_CNT_EN
    ,
    .o_fetch_count(o_fetch_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    if (a == 32'h4) return 32'h0010_0113;
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  // One clock cycle: drive at negedge, check at posedge+1, update the models.
  task automatic tick(input bit stall, input bit flush, input logic [31:0] rpc,
                      input bit ready, input bit en);
    bit          acc, rv;
    logic [31:0] req_addr, h_inst, h_pc, h_addr;
    logic        h_valid, h_req;
    @(negedge clk);
    i_stall       = stall;
    i_flush       = flush;
    i_redirect_pc = rpc;
    i_imem_ready  = ready;
    clk_en        = en;
    rv            = pend && (pend_lat == 0);
    i_imem_rvalid = rv;
    i_imem_rdata  = rv ? (poison ? poison_data : mem(pend_addr)) : $urandom();
    #1;
    acc      = en && o_imem_req && ready;
    req_addr = o_imem_addr;
    h_inst = o_if_inst; h_pc = o_if_pc; h_valid = o_if_valid;
    h_req  = o_imem_req; h_addr = o_imem_addr;
    if (acc && !flush) begin
      if (req_addr !== exp_req) begin
        bad++; $display("FAIL req_addr actual=%h expected=%h", req_addr, exp_req);
      end
      total++;
    end
    @(posedge clk); #1;
    if (!en) begin
      if ({o_if_inst, o_if_pc, o_if_valid, o_imem_req, o_imem_addr} !==
          {h_inst, h_pc, h_valid, h_req, h_addr}) begin
        bad++; $display("FAIL clk_en_hold inst=%h pc=%h valid=%b req=%b addr=%h expected %h %h %b %b %h",
                        o_if_inst, o_if_pc, o_if_valid, o_imem_req, o_imem_addr,
                        h_inst, h_pc, h_valid, h_req, h_addr);
      end
      total++;
      return;
    end
    if (rv) begin
      if (!flush && !pend_killed && exp_cnt != 32'hFFFF_FFFF) exp_cnt++;
      pend = 0; poison = 0;
    end else if (pend) begin
      pend_lat--;
      if (flush) pend_killed = 1;
    end
    if (acc) begin
      pend = 1; pend_addr = req_addr; pend_killed = flush;
      pend_lat = int'($urandom_range(lat_max, lat_min)) - 1;
    end
    if (flush) begin
      exp_pc  = rpc & ~32'h3;
      exp_req = exp_pc;
      if ({o_if_inst, o_if_pc, o_if_valid} !== {NOP, 32'h0, 1'b0}) begin
        bad++; $display("FAIL flush_bubble inst=%h pc=%h valid=%b", o_if_inst, o_if_pc, o_if_valid);
      end
      total++;
    end else begin
      if (acc) exp_req += 32'd4;
      if (stall) begin
        if ({o_if_inst, o_if_pc, o_if_valid} !== {h_inst, h_pc, h_valid}) begin
          bad++; $display("FAIL stall_hold inst=%h pc=%h valid=%b expected %h %h %b",
                          o_if_inst, o_if_pc, o_if_valid, h_inst, h_pc, h_valid);
        end
        total++;
      end else if (o_if_valid) begin
        if (o_if_pc !== exp_pc || o_if_inst !== mem(exp_pc)) begin
          bad++; $display("FAIL delivery pc=%h inst=%h expected pc=%h inst=%h",
                          o_if_pc, o_if_inst, exp_pc, mem(exp_pc));
        end
        total++;
        exp_pc += 32'd4;
        delivered++;
      end
    end
`ifdef IF_PERF_CNT_EN
    if (o_fetch_count !== exp_cnt) begin
      bad++; $display("FAIL fetch_count actual=%0d expected=%0d", o_fetch_count, exp_cnt);
    end
    total++;
`endif
  endtask

  task automatic test_reset();
    clk_en = 1; i_stall = 0; i_flush = 0; i_redirect_pc = 0;
    i_imem_ready = 0; i_imem_rvalid = 0; i_imem_rdata = 0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    if (o_imem_req !== 1'b0 || o_imem_addr !== 32'h0) begin
      bad++; $display("FAIL reset_req req=%b addr=%h expected 0 00000000", o_imem_req, o_imem_addr);
    end
    total++;
    if ({o_if_inst, o_if_pc, o_if_valid} !== {NOP, 32'h0, 1'b0}) begin
      bad++; $display("FAIL reset_ifid inst=%h pc=%h valid=%b", o_if_inst, o_if_pc, o_if_valid);
    end
    total++;
    pend = 0; pend_killed = 0; poison = 0;
    exp_pc = 0; exp_req = 0; exp_cnt = 0;
    rst_n = 1;
  endtask

  task automatic test_first_fetch();
    lat_min = 1; lat_max = 1;
    tick(0, 0, 0, 1, 1);
    if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h0) begin
      bad++; $display("FAIL first_addr req=%b addr=%h expected 1 00000000", o_imem_req, o_imem_addr);
    end
    total++;
    tick(0, 0, 0, 1, 1);
    if (o_imem_req !== 1'b0) begin
      bad++; $display("FAIL wait_no_req req=%b expected 0", o_imem_req);
    end
    total++;
    tick(0, 0, 0, 1, 1);
    if ({o_if_inst, o_if_pc, o_if_valid} !== {32'h0050_0093, 32'h0, 1'b1}) begin
      bad++; $display("FAIL first_inst inst=%h pc=%h valid=%b expected 00500093 00000000 1",
                      o_if_inst, o_if_pc, o_if_valid);
    end
    total++;
    if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h4) begin
      bad++; $display("FAIL second_addr req=%b addr=%h expected 1 00000004", o_imem_req, o_imem_addr);
    end
    total++;
  endtask

  task automatic test_stall();
    tick(1, 0, 0, 1, 1);
    tick(1, 0, 0, 1, 1);
    tick(1, 0, 0, 1, 1);
    if (o_imem_req !== 1'b0) begin
      bad++; $display("FAIL stall_no_req req=%b expected 0", o_imem_req);
    end
    total++;
    if ({o_if_inst, o_if_pc, o_if_valid} !== {32'h0050_0093, 32'h0, 1'b1}) begin
      bad++; $display("FAIL stall_prev inst=%h pc=%h valid=%b expected 00500093 00000000 1",
                      o_if_inst, o_if_pc, o_if_valid);
    end
    total++;
    tick(0, 0, 0, 1, 1);
    if ({o_if_inst, o_if_pc, o_if_valid} !== {32'h0010_0113, 32'h4, 1'b1}) begin
      bad++; $display("FAIL stall_release inst=%h pc=%h valid=%b expected 00100113 00000004 1",
                      o_if_inst, o_if_pc, o_if_valid);
    end
    total++;
    if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h8) begin
      bad++; $display("FAIL stall_next_addr req=%b addr=%h expected 1 00000008", o_imem_req, o_imem_addr);
    end
    total++;
  endtask

  task automatic test_flush_wait();
    lat_min = 2; lat_max = 2;
    tick(0, 0, 0, 1, 1);
    tick(0, 1, 32'h100, 0, 1);
    poison = 1; poison_data = 32'hDEAD_BEEF;
    lat_min = 1; lat_max = 1;
    tick(0, 0, 0, 0, 1);
    if (o_if_inst === 32'hDEAD_BEEF || o_if_valid !== 1'b0) begin
      bad++; $display("FAIL killed_dropped inst=%h valid=%b expected bubble", o_if_inst, o_if_valid);
    end
    total++;
    if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h100) begin
      bad++; $display("FAIL redirect_addr req=%b addr=%h expected 1 00000100", o_imem_req, o_imem_addr);
    end
    total++;
    tick(0, 0, 0, 1, 1);
    tick(0, 0, 0, 1, 1);
    if ({o_if_pc, o_if_valid} !== {32'h100, 1'b1} || o_if_inst !== mem(32'h100)) begin
      bad++; $display("FAIL redirect_fetch inst=%h pc=%h valid=%b expected %h 00000100 1",
                      o_if_inst, o_if_pc, o_if_valid, mem(32'h100));
    end
    total++;
  endtask

  task automatic test_flush_rvalid();
    tick(0, 0, 0, 1, 1);
    tick(0, 1, 32'h200, 0, 1);
    if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h200) begin
      bad++; $display("FAIL flush_rv_addr req=%b addr=%h expected 1 00000200", o_imem_req, o_imem_addr);
    end
    total++;
    tick(0, 0, 0, 1, 1);
    tick(0, 0, 0, 1, 1);
    if ({o_if_pc, o_if_valid} !== {32'h200, 1'b1} || o_if_inst !== mem(32'h200)) begin
      bad++; $display("FAIL flush_rv_next inst=%h pc=%h valid=%b expected %h 00000200 1",
                      o_if_inst, o_if_pc, o_if_valid, mem(32'h200));
    end
    total++;
  endtask

  task automatic test_pc_wrap();
    tick(0, 1, 32'hFFFF_FFFE, 0, 1);
    if (o_imem_req !== 1'b1 || o_imem_addr !== 32'hFFFF_FFFC) begin
      bad++; $display("FAIL wrap_first_addr req=%b addr=%h expected 1 fffffffc", o_imem_req, o_imem_addr);
    end
    total++;
    tick(0, 0, 0, 1, 1);
    tick(0, 0, 0, 1, 1);
    if ({o_if_pc, o_if_valid} !== {32'hFFFF_FFFC, 1'b1}) begin
      bad++; $display("FAIL wrap_inst pc=%h valid=%b expected fffffffc 1", o_if_pc, o_if_valid);
    end
    total++;
    if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h0) begin
      bad++; $display("FAIL wrap_second_addr req=%b addr=%h expected 1 00000000", o_imem_req, o_imem_addr);
    end
    total++;
  endtask

  task automatic test_reset_mid_wait();
    lat_min = 3; lat_max = 3;
    tick(0, 0, 0, 1, 1);
    rst_n = 0;
    #1;
    if (o_imem_req !== 1'b0 || o_imem_addr !== 32'h0 ||
        {o_if_inst, o_if_pc, o_if_valid} !== {NOP, 32'h0, 1'b0}) begin
      bad++; $display("FAIL async_reset req=%b addr=%h inst=%h pc=%h valid=%b",
                      o_imem_req, o_imem_addr, o_if_inst, o_if_pc, o_if_valid);
    end
    total++;
`ifdef IF_PERF_CNT_EN
    if (o_fetch_count !== 32'h0) begin
      bad++; $display("FAIL reset_count actual=%0d expected=0", o_fetch_count);
    end
    total++;
`endif
    pend = 0; pend_killed = 0; poison = 0;
    exp_pc = 0; exp_req = 0; exp_cnt = 0;
    lat_min = 1; lat_max = 1;
    @(posedge clk); #1;
    rst_n = 1;
    tick(0, 0, 0, 1, 1);
    if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h0) begin
      bad++; $display("FAIL reset_first_addr req=%b addr=%h expected 1 00000000", o_imem_req, o_imem_addr);
    end
    total++;
    tick(0, 0, 0, 1, 1);
    tick(0, 0, 0, 1, 1);
    if ({o_if_inst, o_if_pc, o_if_valid} !== {32'h0050_0093, 32'h0, 1'b1}) begin
      bad++; $display("FAIL reset_refetch inst=%h pc=%h valid=%b expected 00500093 00000000 1",
                      o_if_inst, o_if_pc, o_if_valid);
    end
    total++;
  endtask

  task automatic test_random();
    int d0;
    lat_min = 1; lat_max = 4;
    d0 = delivered;
    for (int i = 0; i < 1500; i++) begin
      tick($urandom_range(99, 0) < 30, $urandom_range(99, 0) < 4, $urandom(),
           $urandom_range(99, 0) < 60, $urandom_range(99, 0) < 85);
    end
    for (int i = 0; i < 20; i++) tick(0, 0, 0, 1, 1);
    if (delivered - d0 <= 50) begin
      bad++; $display("FAIL random_progress delivered=%0d required>50", delivered - d0);
    end
    total++;
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_stall();
    test_flush_wait();
    test_flush_rvalid();
    test_pc_wrap();
    test_reset_mid_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
